// File: rtl/smac_operand_sequencer.sv
// Operand-pair sequencer driving one smac column; tracks MAC latency and buffers results in a FIFO.
// Optional macro SMAC_SEQ_ACC_EN: accumulate a job's results lane-wise and emit only the final sum.
module smac_operand_sequencer #(
  parameter int         DATA_WIDTH  = 64,
  parameter int         MAC_LATENCY = 2,
  parameter int         LEN_W       = 16,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [3:0] PREC_INT8   = 4'd1,
  parameter logic [3:0] PREC_INT16  = 4'd2,
  parameter logic [3:0] PREC_INT32  = 4'd4,
  parameter logic [3:0] PREC_INT64  = 4'd8
) (
  input  logic                  clk,
  input  logic                  sclr,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [3:0]            cfg_precision,
  input  logic [1:0]            cfg_fp,
  input  logic [DATA_WIDTH-1:0] cfg_bias,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] op_data,
  input  logic [DATA_WIDTH-1:0] op_weight,
  output logic                  mac_ce,
  output logic                  mac_sclr,
  output logic                  mac_active_chain,
  output logic [DATA_WIDTH-1:0] mac_data_input,
  output logic [DATA_WIDTH-1:0] mac_weight,
  output logic [DATA_WIDTH-1:0] mac_res_p,
  output logic [3:0]            mac_select_precision,
  output logic [1:0]            mac_enable_fp_unit,
  input  logic [DATA_WIDTH-1:0] mac_res_n,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_last,
  output logic                  busy,
  output logic                  err_cfg
);

  localparam int              PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0]     DEPTH_U = 32'(FIFO_DEPTH);
  localparam logic [PW-1:0]   PTR_MAX = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN} state_t;

  state_t                  r_state;
  logic                    r_mac_ce, r_mac_sclr, r_err;
  logic [LEN_W-1:0]        r_rem;
  logic [3:0]              r_prec;
  logic [1:0]              r_fp;
  logic [DATA_WIDTH-1:0]   r_bias;
  logic [MAC_LATENCY-1:0]  r_trk_vld_p1, r_trk_last_p1;
  logic [DATA_WIDTH:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wr, r_rd;
  logic [CW-1:0]           r_cnt;

  logic [31:0]             w_inflight;
  logic                    w_credit_ok, w_issue, w_exit, w_exit_last;
  logic                    w_push, w_push_last, w_pop, w_empty;
  logic [DATA_WIDTH-1:0]   w_push_data;
  logic [DATA_WIDTH:0]     w_head;

  function automatic logic [31:0] f_popcnt(input logic [MAC_LATENCY-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < MAC_LATENCY; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  function automatic logic f_prec_legal(input logic [3:0] p);
    return (p == PREC_INT8) || (p == PREC_INT16) || (p == PREC_INT32) || (p == PREC_INT64);
  endfunction

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  // Credits reserve a FIFO slot for every beat still in the MAC pipeline.
  assign w_inflight  = f_popcnt(r_trk_vld_p1);
  assign w_credit_ok = (32'(r_cnt) + w_inflight + 32'd1) <= DEPTH_U;
  assign w_issue     = (r_state == S_STREAM) && op_valid && w_credit_ok;
  assign w_exit      = r_trk_vld_p1[MAC_LATENCY-1];
  assign w_exit_last = r_trk_last_p1[MAC_LATENCY-1];
  assign w_empty     = (r_cnt == '0);
  assign w_pop       = !w_empty && res_ready;
  assign w_push_last = w_exit_last;

`ifdef SMAC_SEQ_ACC_EN
  logic [DATA_WIDTH-1:0] r_acc, w_acc_sum;

  // Carry is cut at every lane boundary of the selected precision.
  function automatic logic [DATA_WIDTH-1:0] f_lane_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b,
                                                      input logic [3:0]            p);
    logic [DATA_WIDTH-1:0] s;
    logic                  c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (((p == PREC_INT8) && (i % 8 == 0)) || ((p == PREC_INT16) && (i % 16 == 0)) ||
          ((p == PREC_INT32) && (i % 32 == 0)) || (i % 64 == 0))
        c = 1'b0;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return s;
  endfunction

  assign w_acc_sum   = f_lane_add(r_acc, mac_res_n, r_prec);
  assign w_push      = w_exit && w_exit_last;
  assign w_push_data = w_acc_sum;

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) r_acc <= '0;
    else if (w_exit)        r_acc <= w_acc_sum;
  end
`else
  assign w_push      = w_exit;
  assign w_push_data = mac_res_n;
`endif

  // Job FSM with registered smac control and latched descriptor
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state    <= S_IDLE;
      r_mac_ce   <= 1'b0;
      r_mac_sclr <= 1'b1;
      r_err      <= 1'b0;
      r_rem      <= '0;
      r_prec     <= '0;
      r_fp       <= '0;
      r_bias     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mac_sclr <= 1'b0;
          if (cfg_valid) begin
            if ((cfg_len == '0) || !f_prec_legal(cfg_precision)) begin
              r_err <= 1'b1;
            end else begin
              r_rem      <= cfg_len;
              r_prec     <= cfg_precision;
              r_fp       <= cfg_fp;
              r_bias     <= cfg_bias;
              r_mac_sclr <= 1'b1;
              r_state    <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          r_mac_sclr <= 1'b0;
          r_mac_ce   <= 1'b1;
          r_state    <= S_STREAM;
        end
        S_STREAM: begin
          if (w_issue) begin
            r_rem <= r_rem - 1'b1;
            if (r_rem == LEN_W'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((r_trk_vld_p1 == '0) && w_empty) begin
            r_mac_ce <= 1'b0;
            r_prec   <= '0;
            r_fp     <= '0;
            r_bias   <= '0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // In-flight tracker: one stage per MAC pipeline cycle
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_trk_vld_p1  <= '0;
      r_trk_last_p1 <= '0;
    end else begin
      r_trk_vld_p1[0]  <= w_issue;
      r_trk_last_p1[0] <= w_issue && (r_rem == LEN_W'(1));
      for (int i = 1; i < MAC_LATENCY; i++) begin
        r_trk_vld_p1[i]  <= r_trk_vld_p1[i-1];
        r_trk_last_p1[i] <= r_trk_last_p1[i-1];
      end
    end
  end

  // Result FIFO
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= f_ptr_inc(r_wr);
      if (w_pop)  r_rd <= f_ptr_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {w_push_last, w_push_data};
  end

  assert property (@(posedge clk) disable iff (sclr)
    !(w_push && !w_pop && (r_cnt == CW'(FIFO_DEPTH))));

  assign w_head               = r_mem[r_rd];
  assign res_valid            = !w_empty;
  assign res_data             = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  assign res_last             = !w_empty && w_head[DATA_WIDTH];
  assign cfg_ready            = (r_state == S_IDLE);
  assign busy                 = (r_state != S_IDLE);
  assign op_ready             = (r_state == S_STREAM) && w_credit_ok;
  assign err_cfg              = r_err;
  assign mac_ce               = r_mac_ce;
  assign mac_sclr             = r_mac_sclr;
  assign mac_active_chain     = 1'b0;
  assign mac_data_input       = w_issue ? op_data : '0;
  assign mac_weight           = w_issue ? op_weight : '0;
  assign mac_res_p            = r_bias;
  assign mac_select_precision = r_prec;
  assign mac_enable_fp_unit   = r_fp;

endmodule

// File: tb/tb_smac_operand_sequencer.sv
// Testbench for smac_operand_sequencer with a two-stage behavioural smac and a result scoreboard.
module tb_smac_operand_sequencer;
  localparam logic [3:0] P8 = 4'd1, P16 = 4'd2, P32 = 4'd4, P64 = 4'd8;

  logic        clk = 1'b0;
  logic        sclr, cfg_valid, cfg_ready, op_valid, op_ready;
  logic [15:0] cfg_len;
  logic [3:0]  cfg_precision, mac_select_precision;
  logic [1:0]  cfg_fp, mac_enable_fp_unit;
  logic [63:0] cfg_bias, op_data, op_weight, mac_data_input, mac_weight, mac_res_p, mac_res_n, res_data;
  logic        mac_ce, mac_sclr, mac_active_chain, res_valid, res_ready, res_last, busy, err_cfg;

  always #5 clk = ~clk;

  smac_operand_sequencer dut (
    .clk(clk), .sclr(sclr), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
    .cfg_precision(cfg_precision), .cfg_fp(cfg_fp), .cfg_bias(cfg_bias),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_weight(op_weight),
    .mac_ce(mac_ce), .mac_sclr(mac_sclr), .mac_active_chain(mac_active_chain),
    .mac_data_input(mac_data_input), .mac_weight(mac_weight), .mac_res_p(mac_res_p),
    .mac_select_precision(mac_select_precision), .mac_enable_fp_unit(mac_enable_fp_unit),
    .mac_res_n(mac_res_n), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy), .err_cfg(err_cfg)
  );

  // Behavioural smac: input register then output register
  logic [63:0] s1, s2;
  always_ff @(posedge clk) begin
    if (mac_sclr) begin
      s1 <= '0;
      s2 <= '0;
    end else if (mac_ce) begin
      s1 <= mac_data_input * mac_weight + mac_res_p;
      s2 <= s1;
    end
  end
  assign mac_res_n = s2;

  int          total = 0, bad = 0;
  logic [63:0] src_d[$], src_w[$], exp_d[$], obs_d[$];
  logic        exp_l[$], obs_l[$];
  logic [63:0] cur_bias;
  bit          rr_en, sclr_seen, smp_busy;
  int          cyc, t_clear, t_res, issues, drops;

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic clear_sb();
    src_d.delete(); src_w.delete(); exp_d.delete(); exp_l.delete(); obs_d.delete(); obs_l.delete();
    t_clear = -1; t_res = -1; issues = 0; drops = 0; sclr_seen = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (src_d.size() > 0) begin
      op_valid = 1'b1; op_data = src_d[0]; op_weight = src_w[0];
    end else begin
      op_valid = 1'b0; op_data = '0; op_weight = '0;
    end
    res_ready = rr_en;
    #1;
    cyc++;
    if (mac_sclr) sclr_seen = 1'b1;
    if (mac_sclr && busy && t_clear < 0) t_clear = cyc;
    if (res_valid && t_res < 0) t_res = cyc;
    if (op_valid && !op_ready && !mac_sclr && busy) drops++;
    if (op_valid && op_ready) begin
      exp_d.push_back(op_data * op_weight + cur_bias);
      exp_l.push_back(src_d.size() == 1);
      void'(src_d.pop_front());
      void'(src_w.pop_front());
      issues++;
    end
    if (res_valid && res_ready) begin
      obs_d.push_back(res_data);
      obs_l.push_back(res_last);
    end
    smp_busy = busy;
    @(posedge clk);
  endtask

  task automatic start_job(input logic [15:0] len, input logic [3:0] prec, input logic [1:0] fp,
                           input logic [63:0] bias);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_len = len; cfg_precision = prec; cfg_fp = fp; cfg_bias = bias;
    cur_bias = bias;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic run_idle(input int budget, output bit to);
    to = 1'b1;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (!smp_busy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    sclr = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    sclr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sclr = 1'b1; cfg_valid = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    cfg_len = '0; cfg_precision = '0; cfg_fp = '0; cfg_bias = '0; op_data = '0; op_weight = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({cfg_ready, op_ready, res_valid, busy, err_cfg, mac_ce, mac_sclr, mac_active_chain} !== 8'b1000_0010) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=10000010",
               {cfg_ready, op_ready, res_valid, busy, err_cfg, mac_ce, mac_sclr, mac_active_chain});
    end
    total++;
    if ({mac_data_input, mac_weight, mac_res_p, res_data, mac_select_precision, mac_enable_fp_unit, res_last} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", mac_data_input, mac_weight, mac_res_p, res_data);
    end
    @(negedge clk);
    sclr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    bit to;
    clear_sb();
    rr_en = 1'b1;
    src_d.push_back(64'd3); src_w.push_back(64'd5);
    start_job(16'd1, P64, 2'b01, 64'd1);
    total++;
    if ({mac_sclr, mac_ce, busy, cfg_ready} !== 4'b1010) begin
      bad++;
      $display("FAIL single_clear got=%b exp=1010", {mac_sclr, mac_ce, busy, cfg_ready});
    end
    total++;
    if ({mac_select_precision, mac_enable_fp_unit, mac_res_p} !== {P64, 2'b01, 64'd1}) begin
      bad++;
      $display("FAIL single_desc got=%h/%h/%h exp=%h/1/1", mac_select_precision, mac_enable_fp_unit, mac_res_p, P64);
    end
    run_idle(50, to);
    total++;
    if (to) begin bad++; $display("FAIL single_timeout got=busy exp=idle"); end
    total++;
    if (obs_d.size() != 1 || exp_d.size() != 1) begin
      bad++;
      $display("FAIL single_count got=%0d exp=1", obs_d.size());
    end
    while (obs_d.size() > 0 && exp_d.size() > 0) begin
      total++;
      if (obs_d[0] !== 64'd16 || exp_d[0] !== 64'd16 || obs_l[0] !== 1'b1) begin
        bad++;
        $display("FAIL single_data got=%0d/%b exp=16/1", obs_d[0], obs_l[0]);
      end
      void'(obs_d.pop_front()); void'(obs_l.pop_front());
      void'(exp_d.pop_front()); void'(exp_l.pop_front());
    end
    total++;
    if (t_clear < 0 || t_res < 0 || (t_res - t_clear) > 4) begin
      bad++;
      $display("FAIL single_latency got=%0d exp<=4", t_res - t_clear);
    end
    @(negedge clk);
    total++;
    if ({busy, mac_ce, mac_select_precision, mac_res_p} !== '0) begin
      bad++;
      $display("FAIL single_idle got=%b/%b/%h/%h exp=0", busy, mac_ce, mac_select_precision, mac_res_p);
    end
  endtask

  task automatic test_stream();
    bit to;
    clear_sb();
    rr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin src_d.push_back(64'(i)); src_w.push_back(64'd2); end
    start_job(16'd8, P64, 2'b00, 64'd0);
    run_idle(100, to);
    total++;
    if (to || drops != 0 || issues != 8) begin
      bad++;
      $display("FAIL stream_flow got=to%0d/drops%0d/issues%0d exp=to0/drops0/issues8", to, drops, issues);
    end
    total++;
    if (obs_d.size() != 8 || exp_d.size() != 8) begin
      bad++;
      $display("FAIL stream_count got=%0d exp=8", obs_d.size());
    end
    while (obs_d.size() > 0 && exp_d.size() > 0) begin
      total++;
      if (obs_d[0] !== exp_d[0] || obs_l[0] !== exp_l[0]) begin
        bad++;
        $display("FAIL stream_data got=%0d/%b exp=%0d/%b", obs_d[0], obs_l[0], exp_d[0], exp_l[0]);
      end
      void'(obs_d.pop_front()); void'(obs_l.pop_front());
      void'(exp_d.pop_front()); void'(exp_l.pop_front());
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_sb();
    rr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin src_d.push_back(64'(i)); src_w.push_back(64'd2); end
    start_job(16'd8, P64, 2'b00, 64'd0);
    repeat (20) tick();
    #1;
    total++;
    if (issues != 4 || exp_d.size() != 4 || obs_d.size() != 0) begin
      bad++;
      $display("FAIL bp_issues got=%0d/%0d exp=4/0", issues, obs_d.size());
    end
    total++;
    if ({op_ready, res_valid, busy} !== 3'b011) begin
      bad++;
      $display("FAIL bp_state got=%b exp=011", {op_ready, res_valid, busy});
    end
    rr_en = 1'b1;
    run_idle(100, to);
    total++;
    if (to || obs_d.size() != 8 || exp_d.size() != 8) begin
      bad++;
      $display("FAIL bp_count got=to%0d/%0d exp=to0/8", to, obs_d.size());
    end
    while (obs_d.size() > 0 && exp_d.size() > 0) begin
      total++;
      if (obs_d[0] !== exp_d[0] || obs_l[0] !== exp_l[0]) begin
        bad++;
        $display("FAIL bp_data got=%0d/%b exp=%0d/%b", obs_d[0], obs_l[0], exp_d[0], exp_l[0]);
      end
      void'(obs_d.pop_front()); void'(obs_l.pop_front());
      void'(exp_d.pop_front()); void'(exp_l.pop_front());
    end
  endtask

  task automatic test_cfg_error();
    bit to;
    do_reset();
    clear_sb();
    rr_en = 1'b1;
    start_job(16'd0, P64, 2'b00, 64'd0);
    repeat (3) tick();
    total++;
    if ({err_cfg, smp_busy, sclr_seen} !== 3'b100) begin
      bad++;
      $display("FAIL err_len0 got=%b exp=100", {err_cfg, smp_busy, sclr_seen});
    end
    do_reset();
    clear_sb();
    start_job(16'd1, 4'hF, 2'b00, 64'd0);
    repeat (3) tick();
    total++;
    if ({err_cfg, smp_busy, sclr_seen} !== 3'b100) begin
      bad++;
      $display("FAIL err_prec got=%b exp=100", {err_cfg, smp_busy, sclr_seen});
    end
    src_d.push_back(64'd4); src_w.push_back(64'd6);
    src_d.push_back(64'd10); src_w.push_back(64'd10);
    start_job(16'd2, P32, 2'b00, 64'd2);
    run_idle(60, to);
    total++;
    if (to || obs_d.size() != 2 || err_cfg !== 1'b1) begin
      bad++;
      $display("FAIL err_recover got=to%0d/%0d/err%b exp=to0/2/err1", to, obs_d.size(), err_cfg);
    end
    while (obs_d.size() > 0 && exp_d.size() > 0) begin
      total++;
      if (obs_d[0] !== exp_d[0] || obs_l[0] !== exp_l[0]) begin
        bad++;
        $display("FAIL err_data got=%0d/%b exp=%0d/%b", obs_d[0], obs_l[0], exp_d[0], exp_l[0]);
      end
      void'(obs_d.pop_front()); void'(obs_l.pop_front());
      void'(exp_d.pop_front()); void'(exp_l.pop_front());
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    clear_sb();
    rr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin src_d.push_back(64'(i + 1)); src_w.push_back(64'd3); end
    start_job(16'd8, P64, 2'b10, 64'd0);
    repeat (4) tick();
    @(negedge clk);
    sclr = 1'b1; op_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({res_valid, cfg_ready, mac_sclr, busy} !== 4'b0110) begin
      bad++;
      $display("FAIL midrst_state got=%b exp=0110", {res_valid, cfg_ready, mac_sclr, busy});
    end
    @(negedge clk);
    sclr = 1'b0;
    clear_sb();
    src_d.push_back(64'd7); src_w.push_back(64'd3);
    src_d.push_back(64'd9); src_w.push_back(64'd3);
    start_job(16'd2, P64, 2'b00, 64'd5);
    run_idle(60, to);
    repeat (5) tick();
    total++;
    if (to || obs_d.size() != 2 || exp_d.size() != 2) begin
      bad++;
      $display("FAIL midrst_count got=to%0d/%0d exp=to0/2", to, obs_d.size());
    end
    while (obs_d.size() > 0 && exp_d.size() > 0) begin
      total++;
      if (obs_d[0] !== exp_d[0] || obs_l[0] !== exp_l[0]) begin
        bad++;
        $display("FAIL midrst_data got=%0d/%b exp=%0d/%b", obs_d[0], obs_l[0], exp_d[0], exp_l[0]);
      end
      void'(obs_d.pop_front()); void'(obs_l.pop_front());
      void'(exp_d.pop_front()); void'(exp_l.pop_front());
    end
  endtask

  task automatic test_acc();
    bit to;
    clear_sb();
    rr_en = 1'b1;
    repeat (2) begin src_d.push_back(64'h8080_8080_8080_8080); src_w.push_back(64'd1); end
    start_job(16'd2, P8, 2'b00, 64'd0);
    run_idle(60, to);
    total++;
    if (to || obs_d.size() != 1) begin
      bad++;
      $display("FAIL acc_count got=to%0d/%0d exp=to0/1", to, obs_d.size());
    end
    if (obs_d.size() > 0) begin
      total++;
      if (obs_d[0] !== 64'd0 || obs_l[0] !== 1'b1) begin
        bad++;
        $display("FAIL acc_data got=%h/%b exp=0/1", obs_d[0], obs_l[0]);
      end
    end
  endtask

  initial begin
    cyc = 0;
    cur_bias = '0;
    rr_en = 1'b1;
    test_reset();
`ifdef SMAC_SEQ_ACC_EN
    test_acc();
`else
    test_single();
    test_stream();
    test_backpressure();
    test_cfg_error();
    test_mid_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/smac_operand_sequencer.md
Name: smac_operand_sequencer

Overview:
- Initiator side of the smac interface: accepts operand-pair beats over valid/ready and drives one smac instance's ce/sclr/data_input/weight/res_mac_p/select_precision/enable_fp_unit/active_chain.
- Tracks the MAC pipeline latency and captures res_mac_n into a result FIFO, re-emitted as a valid/ready stream.
- Sits between the DTPU operand fetch logic and each smac column; converts the free-running MAC pipeline into a back-pressurable job engine.

Parameters:
- DATA_WIDTH, 64, operand/result word width (matches smac).
- MAC_LATENCY, 2, cycles from an issued beat to its valid res_mac_n.
- LEN_W, 16, width of job beat count.
- FIFO_DEPTH, 4, result FIFO entries; must be >= MAC_LATENCY+1.

Ports:
- clk  in  1  clock
- sclr  in  1  synchronous active-high reset
- cfg_valid  in  1  job descriptor valid
- cfg_ready  out  1  sequencer idle, descriptor accepted when both high
- cfg_len  in  LEN_W  beats in job; 0 is illegal
- cfg_precision  in  4  precision code (`INT8/`INT16/`INT32/`INT64 from precision_def.vh)
- cfg_fp  in  2  value driven onto mac_enable_fp_unit for the job
- cfg_bias  in  DATA_WIDTH  value driven on mac_res_p for every beat
- op_valid / op_ready  in / out  1  operand handshake
- op_data, op_weight  in  DATA_WIDTH  operand pair
- mac_ce, mac_sclr, mac_active_chain  out  1  to smac
- mac_data_input, mac_weight, mac_res_p  out  DATA_WIDTH  to smac
- mac_select_precision  out  4;  mac_enable_fp_unit  out  2
- mac_res_n  in  DATA_WIDTH  smac result
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  DATA_WIDTH  result word
- res_last  out  1  final result of job
- busy  out  1  state != IDLE
- err_cfg  out  1  sticky; illegal descriptor seen

Behaviour:
- Reset (sclr high at a clk edge): all state to IDLE; FIFO, in-flight tracker and counters cleared. Outputs: cfg_ready=1, op_ready=0, res_valid=0, busy=0, err_cfg=0, mac_ce=0, mac_sclr=1, mac_active_chain=0, all data outputs 0.
- FSM IDLE -> CLEAR -> STREAM -> DRAIN -> IDLE.
- IDLE:
  - cfg_valid & cfg_ready: if cfg_len==0 or the precision code is not one of the four legal codes, set err_cfg, drop the job, stay in IDLE.
  - Otherwise latch the descriptor and go to CLEAR.
- CLEAR: exactly one cycle with mac_sclr=1, mac_ce=0; then STREAM.
- STREAM:
  - mac_ce=1 continuously.
  - op_ready = credit_ok, where credit_ok = (fifo_count + inflight + 1 <= FIFO_DEPTH). Both counts are taken before the current cycle's updates.
  - On op_valid & op_ready (an issue), drive the operands to mac_data_input/mac_weight in the same cycle (combinational pass-through, registered at smac) and decrement the remaining count.
  - Non-issue cycles drive zeros (bubble).
  - After the last issue, go to DRAIN.
- In-flight tracker: MAC_LATENCY-deep valid shift register plus a last-flag shift register. A bit exiting the tracker pushes mac_res_n into the FIFO with its last flag.
- DRAIN: op_ready=0, mac_ce=1. Return to IDLE when the tracker is empty and the FIFO is empty (last result popped).
- mac_res_p=cfg_bias, mac_select_precision and mac_enable_fp_unit are held from the latched descriptor while busy; 0 in IDLE. mac_active_chain=0 always.
- FIFO:
  - res_valid = !empty; res_data/res_last from head; pop on res_valid & res_ready.
  - A push and a pop in the same cycle are both honoured. Credit accounting guarantees no push when full; overflow is an assertion failure.
- cfg_ready=1 only in IDLE; a descriptor arriving while busy is ignored (no latch, no error).
- res_ready low never stalls the MAC pipeline; back-pressure reaches op_ready via credits only.
- Reset mid-job discards all in-flight and buffered results; no res_last is emitted for that job.

Optional Feature:
- Macro SMAC_SEQ_ACC_EN.
- Defined:
  - Results are summed into an accumulator instead of being pushed per beat.
  - Addition is lane-wise per the latched precision: 8/16/32/64-bit lanes, carries do not cross lanes, each lane wraps modulo 2^lane.
  - Only the final sum is pushed, with res_last=1; the accumulator clears in CLEAR.
- Undefined: one result per beat, as above.

Test Plan:
- `INT64, len=1, bias=1, data=3, weight=5 -> one result 16 with res_last=1, CLEAR-to-res_valid <= MAC_LATENCY+2 cycles, busy returns to 0.
- `INT64, len=8, data=i, weight=2, bias=0, res_ready=1 -> results 0,2,...,14 in order, op_ready never drops, res_last only on 14.
- Same job with res_ready=0 for 20 cycles -> op_ready drops after 4 issues, exactly 4 entries buffered, no loss, all 8 results correct once released.
- cfg_len=0, then an illegal precision code -> err_cfg=1, busy stays 0, no mac_sclr pulse; a subsequent legal job still completes.
- sclr asserted mid-STREAM of a len=8 job -> next cycle: res_valid=0, cfg_ready=1, mac_sclr=1; a fresh len=2 job yields exactly 2 results.
- With SMAC_SEQ_ACC_EN defined, `INT8, len=2, each beat lane result 0x80 -> single result with every byte 0x00 (lane wrap, no carry into the next lane).
